// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit seven-segment display.
// Holds the displayed hex value and digit enables and walks an active-low anode across the digits.
// It presents the selected nibble and a decoder enable with one registered cycle of latency.
// New values are taken through a valid/ready pending register.
// A pending value is copied to the active value only at a frame wrap, so the display never tears.
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
// Leading-zero blanking uses a digit index registered when a new value is committed.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int DIV_MAX      = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iValid,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic [DIGITS-1:0]     iDigitEn,
  output logic                  oReady,
  output logic [DIGITS-1:0]     oAn,
  output logic [3:0]            oData,
  output logic                  oEna,
  output logic                  oFrame
);

  localparam int CNT_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_idx;

  // Active (displayed) and pending (waiting for frame wrap) value/enable
  logic [4*DIGITS-1:0] r_act_val;
  logic [DIGITS-1:0]   r_act_en;
  logic [4*DIGITS-1:0] r_pend_val;
  logic [DIGITS-1:0]   r_pend_en;
  logic                r_pend_full;

  // Registered outputs
  logic [DIGITS-1:0]   r_an;
  logic [3:0]          r_data;
  logic                r_ena;
  logic                r_frame;

  logic                w_slot_end;
  logic                w_wrap;
  logic                w_accept;
  logic                w_commit;
  logic                w_blank;
  logic                w_shown;
  logic                w_lit;
  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_an_sel;

  assign w_slot_end = (r_div_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_accept   = iValid && !r_pend_full;
  // Commit only ever happens with the pending register full, so accept and commit never collide.
  assign w_commit   = w_wrap && r_pend_full;
  assign w_blank    = (r_div_cnt < CNT_BLANK);

  // Per-digit nibble slices of the active value and the one-hot active-low anode decode
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_nib[gi]    = r_act_val[4*gi +: 4];
    assign w_an_sel[gi] = (r_idx != IDX_W'(gi));
  end

`ifdef SEG_LZB_EN
  logic [IDX_W-1:0] r_msd;
  logic [IDX_W-1:0] w_msd_next;

  // Highest enabled non-zero digit of the value about to be committed; digit 0 when all are zero
  always_comb begin
    w_msd_next = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_pend_en[k] && (r_pend_val[4*k +: 4] != 4'h0)) begin
        w_msd_next = IDX_W'(k);
      end
    end
  end

  // Most-significant shown digit, updated together with the active value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msd <= '0;
    end else if (w_commit) begin
      r_msd <= w_msd_next;
    end
  end

  assign w_shown = r_act_en[r_idx] && (r_idx <= r_msd);
`else
  assign w_shown = r_act_en[r_idx];
`endif

  assign w_lit = !w_blank && w_shown;

  // Slot divider and digit index; the index advances when a slot ends and wraps after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  // Load handshake into pending and commit of pending to active at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_val   <= '0;
      r_act_en    <= '0;
      r_pend_val  <= '0;
      r_pend_en   <= '0;
      r_pend_full <= 1'b0;
    end else if (w_commit) begin
      r_act_val   <= r_pend_val;
      r_act_en    <= r_pend_en;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_val  <= iValue;
      r_pend_en   <= iDigitEn;
      r_pend_full <= 1'b1;
    end
  end

  // Display outputs registered from the current scan position; the frame pulse marks the last slot ending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an    <= '1;
      r_data  <= '0;
      r_ena   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      r_data  <= w_nib[r_idx];
      if (w_lit) begin
        r_an  <= w_an_sel;
        r_ena <= 1'b1;
      end else begin
        r_an  <= '1;
        r_ena <= 1'b0;
      end
    end
  end

  assign oReady = !r_pend_full;
  assign oAn    = r_an;
  assign oData  = r_data;
  assign oEna   = r_ena;
  assign oFrame = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (DIGITS=8, DIV_MAX=4, BLANK_CYCLES=1).
// A behavioural model pushes the expected outputs for each cycle into a scoreboard queue.
// Each expected entry is popped and compared after the clock edge.
// Directed checks cover the scenarios listed for the block.
module tb_seg_scan_ctrl;
  localparam int DIGITS  = 8;
  localparam int DIV_MAX = 4;
  localparam int BLANK   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iValid = 1'b0;
  logic [31:0] iValue = '0;
  logic [7:0]  iDigitEn = '0;
  logic        oReady;
  logic [7:0]  oAn;
  logic [3:0]  oData;
  logic        oEna;
  logic        oFrame;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(DIGITS),
    .DIV_MAX(DIV_MAX),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iValid(iValid),
    .iValue(iValue),
    .iDigitEn(iDigitEn),
    .oReady(oReady),
    .oAn(oAn),
    .oData(oData),
    .oEna(oEna),
    .oFrame(oFrame)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [3:0] data;
    logic       ena;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t sb_q[$];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model state
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_act_val;
  logic [7:0]  m_act_en;
  logic [31:0] m_pend_val;
  logic [7:0]  m_pend_en;
  logic        m_pend_full;
  int          m_msd;

  int          frames_seen = 0;
  logic [7:0]  an_low_seen = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int msd_of(input logic [31:0] val, input logic [7:0] en);
    int r = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (en[k] && (val[4*k +: 4] != 4'h0)) r = k;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_act_val = '0;
    m_act_en = '0;
    m_pend_val = '0;
    m_pend_en = '0;
    m_pend_full = 1'b0;
    m_msd = 0;
    sb_q.delete();
  endtask

  // Expected outputs after the coming edge, given the current inputs; advances the model
  task automatic model_step(output exp_t e);
    logic shown;
    shown = m_act_en[m_idx];
`ifdef SEG_LZB_EN
    shown = shown && (m_idx <= m_msd);
`endif
    e.frame = (m_cnt == DIV_MAX - 1) && (m_idx == DIGITS - 1);
    e.data  = m_act_val[4*m_idx +: 4];
    if (m_cnt >= BLANK && shown) begin
      e.an  = ~(8'h01 << m_idx);
      e.ena = 1'b1;
    end else begin
      e.an  = 8'hFF;
      e.ena = 1'b0;
    end
    if (e.frame && m_pend_full) begin
      m_act_val   = m_pend_val;
      m_act_en    = m_pend_en;
      m_msd       = msd_of(m_pend_val, m_pend_en);
      m_pend_full = 1'b0;
    end else if (iValid && !m_pend_full) begin
      m_pend_val  = iValue;
      m_pend_en   = iDigitEn;
      m_pend_full = 1'b1;
    end
    e.ready = !m_pend_full;
    if (m_cnt == DIV_MAX - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % DIGITS;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic tick();
    exp_t e;
    exp_t got;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("an", oAn, got.an);
    check("data", oData, got.data);
    check("ena", oEna, got.ena);
    check("frame", oFrame, got.frame);
    check("ready", oReady, got.ready);
    an_low_seen |= ~oAn;
    if (oFrame) frames_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [31:0] val, input logic [7:0] en);
    iValid = 1'b1;
    iValue = val;
    iDigitEn = en;
    tick();
    iValid = 1'b0;
    iValue = $urandom;
    iDigitEn = 8'($urandom);
  endtask

  task automatic wait_frame();
    int start = frames_seen;
    int guard = 0;
    while (frames_seen == start && guard < 100) begin
      tick();
      guard++;
    end
    check("frame_timeout", guard < 100, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_an"}, oAn, 8'hFF);
    check({tag, "_ena"}, oEna, 0);
    check({tag, "_ready"}, oReady, 1);
    check({tag, "_data"}, oData, 4'h0);
    check({tag, "_frame"}, oFrame, 0);
  endtask

  initial begin
    int guard;
    logic [7:0] exp_lzb1;
    logic [7:0] exp_lzb0;

    // Reset held then released
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    model_reset();
    run(4);
    check("idle_an", oAn, 8'hFF);
    $display("reset/idle: oAn=%h oReady=%b", oAn, oReady);

    // Load a value, then offer another that must be ignored
    load(32'h7654_3210, 8'hFF);
    check("ready_after_load", oReady, 0);
    load(32'hAAAA_AAAA, 8'hFF);
    check("ready_while_full", oReady, 0);
    $display("load 76543210 accepted, AAAAAAAA offered while busy");
    wait_frame();
    check("ready_after_commit", oReady, 1);
    an_low_seen = '0;
    run(32);
    check("walk_all_digits", an_low_seen, 8'hFF);
    $display("frame after commit: anodes seen=%h", an_low_seen);

    // Accept in the wrap cycle: committed only at the following wrap
    guard = 0;
    while (!(m_cnt == DIV_MAX - 1 && m_idx == DIGITS - 1) && guard < 100) begin
      tick();
      guard++;
    end
    check("align_timeout", guard < 100, 1);
    load(32'h1234_5678, 8'h0F);
    check("wrap_accept_frame", oFrame, 1);
    check("wrap_accept_pending", oReady, 0);
    run(31);
    check("still_pending_one_frame_later", oReady, 0);
    wait_frame();
    check("ready_after_second_wrap", oReady, 1);
    an_low_seen = '0;
    run(64);
    check("en_0f_anodes", an_low_seen, 8'h0F);
    $display("accept at wrap, en=0F: anodes seen=%h", an_low_seen);

    // Reset mid-frame discards active and pending state
    load(32'hFFFF_FFFF, 8'hFF);
    run(10);
    rst_n = 1'b0;
    #2;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    an_low_seen = '0;
    run(70);
    check("dark_after_midrst", an_low_seen, 8'h00);
    $display("mid-frame reset: anodes seen=%h", an_low_seen);

    // Leading-zero blanking (or plain enables when the feature is off)
`ifdef SEG_LZB_EN
    exp_lzb1 = 8'h07;
    exp_lzb0 = 8'h01;
`else
    exp_lzb1 = 8'hFF;
    exp_lzb0 = 8'hFF;
`endif
    load(32'h0000_0120, 8'hFF);
    wait_frame();
    an_low_seen = '0;
    run(32);
    check("lzb_120", an_low_seen, exp_lzb1);
    $display("value 00000120: anodes seen=%h", an_low_seen);
    load(32'h0000_0000, 8'hFF);
    wait_frame();
    an_low_seen = '0;
    run(32);
    check("lzb_zero", an_low_seen, exp_lzb0);
    $display("value 00000000: anodes seen=%h", an_low_seen);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
